// File: rtl/abcd_pulse_seq_if.sv
// abcd_pulse_seq_if
// Bundle between the command decoder (master) and the ABCD pulse sequencer (slave).
// master drives: en, the four channel delays, duty_cycle, sub_clk_feq, sub_clk_scl.
// master receives: out_a..out_d, period_start, busy.
interface abcd_pulse_seq_if #(
   parameter int CW = 16
);
   logic          en;
   logic [CW-1:0] delay_set_a;
   logic [CW-1:0] delay_set_b;
   logic [CW-1:0] delay_set_c;
   logic [CW-1:0] delay_set_d;
   logic [CW-1:0] duty_cycle;
   logic [CW-1:0] sub_clk_feq;
   logic [CW-1:0] sub_clk_scl;
   logic          out_a;
   logic          out_b;
   logic          out_c;
   logic          out_d;
   logic          period_start;
   logic          busy;

   modport master (
      output en, delay_set_a, delay_set_b, delay_set_c, delay_set_d,
             duty_cycle, sub_clk_feq, sub_clk_scl,
      input  out_a, out_b, out_c, out_d, period_start, busy
   );

   modport slave (
      input  en, delay_set_a, delay_set_b, delay_set_c, delay_set_d,
             duty_cycle, sub_clk_feq, sub_clk_scl,
      output out_a, out_b, out_c, out_d, period_start, busy
   );
endinterface

// File: rtl/abcd_pulse_seq.sv
// abcd_pulse_seq
// Four-channel periodic pulse generator. A prescaler divides clk into ticks, a
// phase counter counts ticks over one period, and each channel is high while
// the phase lies inside [delay, delay+duty). Configuration is shadowed at LOAD
// and at every period wrap so mid-period register writes cannot glitch pulses.
// Ports:
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   slave side of abcd_pulse_seq_if (en + config words in, pulses out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped, outputs low, counters at 0; waits for en
// LOAD  | one clk: capture shadows, zero counters, flag period_start
// RUN   | sequencing; shadows reloaded at every wrap
// STOP  | en dropped; finish the current period, then return to IDLE
module abcd_pulse_seq #(
   parameter int CW = 16
) (
   input  logic             clk,
   input  logic             rstn,
   abcd_pulse_seq_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_STOP = 2'd3;

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [1:0]    state, state_nx;
   logic [CW-1:0] pre_cnt, pre_nx;
   logic [CW-1:0] ph, ph_nx;
   logic [CW-1:0] da_sh, db_sh, dc_sh, dd_sh;
   logic [CW-1:0] duty_sh, feq_sh, scl_sh;
   logic [CW-1:0] scl_eff, feq_eff;
   logic          tick, wrap, reload, ps_nx, running;

   // Window never wraps into the next period because ph stays below feq_eff.
   function automatic logic in_win(input logic [CW-1:0] p, input logic [CW-1:0] d,
                                   input logic [CW-1:0] w);
      return (p >= d) && ((p - d) < w);
   endfunction

   always_comb begin
      scl_eff  = (scl_sh == '0) ? ONE : scl_sh;
      feq_eff  = (feq_sh == '0) ? ONE : feq_sh;
      tick     = (pre_cnt == (scl_eff - ONE));
      wrap     = tick && (ph == (feq_eff - ONE));
      running  = (state == S_RUN) || (state == S_STOP);
      state_nx = state;
      pre_nx   = pre_cnt;
      ph_nx    = ph;
      reload   = 1'b0;
      ps_nx    = 1'b0;
      case (state)
         S_IDLE: begin
            pre_nx = '0;
            ph_nx  = '0;
            if (bus.en) state_nx = S_LOAD;
         end
         S_LOAD: begin
            pre_nx   = '0;
            ph_nx    = '0;
            reload   = 1'b1;
            ps_nx    = 1'b1;
            state_nx = S_RUN;
         end
         S_RUN, S_STOP: begin
            pre_nx = tick ? '0 : pre_cnt + ONE;
            if (tick) ph_nx = wrap ? '0 : ph + ONE;
            if (state == S_RUN)
               state_nx = bus.en ? S_RUN : S_STOP;
            else if (bus.en)
               state_nx = S_RUN;
            else if (wrap)
               state_nx = S_IDLE;
            // A wrap in STOP with en back high behaves like a RUN wrap.
            if (wrap && ((state == S_RUN) || bus.en)) begin
               reload = 1'b1;
               ps_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state            <= S_IDLE;
         pre_cnt          <= '0;
         ph               <= '0;
         da_sh            <= '0;
         db_sh            <= '0;
         dc_sh            <= '0;
         dd_sh            <= '0;
         duty_sh          <= '0;
         feq_sh           <= '0;
         scl_sh           <= '0;
         bus.out_a        <= 1'b0;
         bus.out_b        <= 1'b0;
         bus.out_c        <= 1'b0;
         bus.out_d        <= 1'b0;
         bus.period_start <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         state   <= state_nx;
         pre_cnt <= pre_nx;
         ph      <= ph_nx;
         if (reload) begin
            da_sh   <= bus.delay_set_a;
            db_sh   <= bus.delay_set_b;
            dc_sh   <= bus.delay_set_c;
            dd_sh   <= bus.delay_set_d;
            duty_sh <= bus.duty_cycle;
            feq_sh  <= bus.sub_clk_feq;
            scl_sh  <= bus.sub_clk_scl;
         end
         // Decode uses the shadows of the period ph belongs to (pre-reload).
         bus.out_a        <= running && in_win(ph, da_sh, duty_sh);
         bus.out_b        <= running && in_win(ph, db_sh, duty_sh);
         bus.out_c        <= running && in_win(ph, dc_sh, duty_sh);
         bus.out_d        <= running && in_win(ph, dd_sh, duty_sh);
         bus.period_start <= ps_nx;
         bus.busy         <= (state_nx != S_IDLE);
      end
   end
endmodule

// File: tb/tb_abcd_pulse_seq.sv
// tb_abcd_pulse_seq
// Directed scoreboard bench: each test pushes the hand-derived per-cycle
// expected vector {busy, period_start, out_a, out_b, out_c, out_d}; a monitor
// process pops one entry per cycle at negedge and compares.
module tb_abcd_pulse_seq;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   abcd_pulse_seq_if #(.CW(CW)) bus ();
   abcd_pulse_seq #(.CW(CW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   logic [5:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         pop_n  = 0;
   string      cur_test = "reset";

   localparam logic [5:0] V_ZERO = 6'b000000;
   localparam logic [5:0] V_LOAD = 6'b100000;

   task automatic set_cfg(input logic [CW-1:0] a, input logic [CW-1:0] b,
                          input logic [CW-1:0] c, input logic [CW-1:0] d,
                          input logic [CW-1:0] duty, input logic [CW-1:0] feq,
                          input logic [CW-1:0] scl);
      bus.delay_set_a = a;
      bus.delay_set_b = b;
      bus.delay_set_c = c;
      bus.delay_set_d = d;
      bus.duty_cycle  = duty;
      bus.sub_clk_feq = feq;
      bus.sub_clk_scl = scl;
   endtask

   // Position j of a period counts clk cycles from its period_start cycle.
   // Mask bit j = channel high at position j; position 0 carries the decode of
   // the previous period's last phase, which is always 0 for the first period.
   task automatic push_period(input logic [31:0] ma, input logic [31:0] mb,
                              input logic [31:0] mc, input logic [31:0] md,
                              input bit first, input int cnt);
      logic [5:0] v;
      for (int j = 0; j < cnt; j++) begin
         v = {1'b1, (j == 0), ma[j], mb[j], mc[j], md[j]};
         if (first && j == 0) v[3:0] = 4'b0000;
         exp_q.push_back(v);
      end
   endtask

   // Called while IDLE with en=0: the first expected cycle is still IDLE,
   // then LOAD, then the first period_start cycle.
   task automatic start_run(input string name);
      @(posedge clk);
      #1;
      cur_test = name;
      pop_n    = 0;
      bus.en   = 1'b1;
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_LOAD);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: %0d expected entries left, required 0", cur_test, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rstn   = 1'b0;
      bus.en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      rstn   = 1'b0;
      bus.en = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);

      fork
         forever begin
            logic [5:0] e, got;
            @(negedge clk);
            if (exp_q.size() > 0) begin
               e   = exp_q.pop_front();
               got = {bus.busy, bus.period_start, bus.out_a, bus.out_b, bus.out_c, bus.out_d};
               checks++;
               if (got !== e) begin
                  errors++;
                  $display("FAIL %s cycle %0d: busy/ps/abcd got %b required %b", cur_test, pop_n, got, e);
               end
               pop_n++;
            end
         end
      join_none

      // Reset state
      @(posedge clk);
      #1;
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_ZERO);
      wait_drain();
      #1 rstn = 1'b1;

      // Basic timing
      set_cfg(0, 2, 4, 9, 3, 10, 1);
      start_run("basic");
      push_period('h00E, 'h038, 'h0E0, 'h001, 1, 10);
      push_period('h00E, 'h038, 'h0E0, 'h001, 0, 10);
      push_period('h00E, 'h038, 'h0E0, 'h001, 0, 10);
      wait_drain();
      do_reset();

      // Prescale: 4 clk per tick, ph 1..2 decoded at positions 5..12
      set_cfg(1, 100, 100, 100, 2, 5, 4);
      start_run("prescale");
      push_period('h1FE0, 0, 0, 0, 1, 20);
      push_period('h1FE0, 0, 0, 0, 0, 20);
      wait_drain();
      do_reset();

      // Shadowing: delay_a 0->5 at ph=4 takes effect next period
      set_cfg(0, 20, 20, 20, 3, 10, 1);
      start_run("shadow");
      push_period('h00E, 0, 0, 0, 1, 10);
      push_period('h1C0, 0, 0, 0, 0, 10);
      push_period('h1C0, 0, 0, 0, 0, 10);
      repeat (6) @(posedge clk);
      #1 bus.delay_set_a = 5;
      wait_drain();
      do_reset();

      // Graceful stop: en low at ph=3, period finishes, D's ph=9 decode lands in IDLE
      set_cfg(0, 2, 4, 9, 3, 10, 1);
      start_run("stop");
      push_period('h00E, 'h038, 'h0E0, 'h001, 1, 10);
      exp_q.push_back(6'b000001);
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_ZERO);
      repeat (5) @(posedge clk);
      #1 bus.en = 1'b0;
      wait_drain();

      // Re-raise during STOP: en low at ph=3, high again at ph=6, no gap
      start_run("rerun");
      push_period('h00E, 'h038, 'h0E0, 'h001, 1, 10);
      push_period('h00E, 'h038, 'h0E0, 'h001, 0, 10);
      push_period('h00E, 'h038, 'h0E0, 'h001, 0, 10);
      repeat (15) @(posedge clk);
      #1 bus.en = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.en = 1'b1;
      wait_drain();
      do_reset();

      // Degenerate scl=0, feq=0: wrap every clk, out_a stuck high
      set_cfg(0, 5, 5, 5, 1, 0, 0);
      start_run("zero_scl_feq");
      for (int i = 0; i < 8; i++) push_period('h1, 0, 0, 0, (i == 0), 1);
      wait_drain();
      do_reset();

      // duty=0 plus an rstn glitch that spans no clk edge
      set_cfg(0, 2, 4, 9, 0, 10, 1);
      start_run("duty0_glitch");
      push_period(0, 0, 0, 0, 1, 10);
      push_period(0, 0, 0, 0, 0, 10);
      repeat (5) @(posedge clk);
      #2 rstn = 1'b0;
      #2 rstn = 1'b1;
      wait_drain();
      do_reset();

      // delay_b == feq: out_b never asserts
      set_cfg(0, 10, 4, 9, 3, 10, 1);
      start_run("delay_eq_feq");
      push_period('h00E, 0, 'h0E0, 'h001, 1, 10);
      push_period('h00E, 0, 'h0E0, 'h001, 0, 10);
      wait_drain();
      do_reset();

      // Sync reset at ph=6 with en held high: clear, then LOAD, then fresh period
      set_cfg(0, 2, 4, 9, 3, 10, 1);
      start_run("reset_mid");
      push_period('h00E, 'h038, 'h0E0, 'h001, 1, 7);
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_LOAD);
      push_period('h00E, 'h038, 'h0E0, 'h001, 1, 10);
      push_period('h00E, 'h038, 'h0E0, 'h001, 0, 10);
      repeat (8) @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
